park_mul_seq: RTL and testbench
===============================

// Module: park_mul_seq
// PURPOSE
//  Sequencer for the Park transform in the FOC current loop. It time-shares the
//  pipelined signed 32x32 multiplier (mul_32bits) to compute:
//    id =  i_alpha*cos + i_beta*sin
//    iq =  i_beta*cos  - i_alpha*sin
//  It drives the multiplier operand inputs and consumes its 64-bit product.
//  It then rounds, rescales and saturates both sums to 32-bit signed values for the PI stage.
// PARAMETERS
//  FRAC_BITS  15  fraction bits of sin_th/cos_th (Q1.FRAC_BITS; 1.0 = 1<<FRAC_BITS)
//  MUL_LAT    2   clock cycles from mul_a/mul_b presented to mul_p valid; range 1..7
// PORTS
//  clk      in   1   clock, rising edge
//  rst_n    in   1   asynchronous reset, active low
//  start    in   1   request; sampled only in IDLE
//  i_alpha  in   32  signed alpha current; sampled with start
//  i_beta   in   32  signed beta current; sampled with start
//  sin_th   in   32  signed sin(theta), Q1.FRAC_BITS; sampled with start
//  cos_th   in   32  signed cos(theta), Q1.FRAC_BITS; sampled with start
//  mul_a    out  32  multiplier operand A (to mul_32bits count_a)
//  mul_b    out  32  multiplier operand B (to mul_32bits count_b)
//  mul_p    in   64  signed product (from mul_32bits result)
//  busy     out  1   high while a transform is in flight
//  done     out  1   one-cycle pulse; id_out/iq_out updated this cycle
//  id_out   out  32  signed d-axis current, held until next done
//  iq_out   out  32  signed q-axis current, held until next done
// BEHAVIOUR
//  Reset:
//   - All outputs are 0 and the FSM is IDLE.
//   - Reset mid-operation aborts the transform: no done pulse, and id_out/iq_out return to 0.
//  Start (cycle T = edge at which start is sampled high in IDLE):
//   - Latch i_alpha, i_beta, sin_th and cos_th.
//   - Any operand equal to 0x80000000 is clamped to 0x80000001, because the multiplier is
//     magnitude-limited to 2^31-1.
//   - busy rises in cycle T+1.
//   - start while busy is ignored and does not queue.
//  FSM states: IDLE -> ISSUE -> DRAIN -> SUM -> OUT -> IDLE.
//   - ISSUE (4 cycles, k = 0..3): during cycle T+1+k, mul_a/mul_b present
//     P0 = alpha*cos, P1 = beta*sin, P2 = beta*cos, P3 = alpha*sin.
//   - mul_a/mul_b are 0 outside ISSUE.
//   - Product k is captured from mul_p at the end of cycle T+1+k+MUL_LAT. A 3-bit counter
//     plus a MUL_LAT-deep tag shift register selects the capture register.
//   - DRAIN: wait until P3 has been captured.
//   - SUM: form 65-bit sums d = P0+P1 and q = P2-P3.
//     - Add 1<<(FRAC_BITS-1) to round half-up.
//     - Arithmetic shift right by FRAC_BITS.
//     - Saturate symmetrically to [0x80000001, 0x7FFFFFFF].
//   - OUT: register id_out/iq_out and pulse done.
//  Timing:
//   - done is high in cycle T+6+MUL_LAT (MUL_LAT=2: 8 cycles after start).
//   - busy falls in the cycle after done; start may be accepted in that same cycle.
//   - Throughput is one transform per 7+MUL_LAT cycles.
//  Multiplier stall: mul_p has no handshake, so the multiplier must never stall.
// TESTING
//  (FRAC_BITS=15, MUL_LAT=2; behavioural pipelined multiplier model on mul_p)
//  1. cos=32768, sin=0, alpha=1000, beta=-500 -> id=1000, iq=-500; done exactly at T+8.
//  2. cos=0, sin=32768, alpha=1000, beta=-500 -> id=-500, iq=-1000.
//  3. alpha=beta=0x7FFFFFFF, cos=sin=32768 -> id=0x7FFFFFFF (saturated), iq=0.
//  4. Rounding with cos=16384, sin=0: alpha=1 -> id=1; alpha=-1 -> id=0; alpha=3 -> id=2.
//  5. alpha=0x80000000, cos=32768, sin=0 -> mul_a shows 0x80000001, id=0x80000001.
//  6. Control events:
//     - start pulsed again at T+3 -> ignored, one done only.
//     - rst_n low at T+4 -> outputs 0, no done.
//     - Next start after reset completes normally.

Source files
------------

// File: rtl/park_mul_seq.sv
// Park transform sequencer: time-shares one pipelined 32x32 multiplier
// to form id/iq, then rounds, rescales and saturates both results.
module park_mul_seq #(
    parameter int FRAC_BITS = 15,
    parameter int MUL_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] i_alpha,
    input  logic [31:0] i_beta,
    input  logic [31:0] sin_th,
    input  logic [31:0] cos_th,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_out,
    output logic [31:0] iq_out
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, DRAIN, SUM, OUT
    } state_t;

    localparam logic signed [64:0] RND = 65'sd1 <<< (FRAC_BITS - 1);
    localparam logic signed [64:0] POS_MAX = 65'sd2147483647;
    localparam logic signed [64:0] NEG_MAX = -65'sd2147483647;

    state_t state, state_nx;

    logic [2:0]  cnt;
    logic [31:0] alpha_q, beta_q, sin_q, cos_q;

    logic [MUL_LAT-1:0] tag_vld;
    logic [1:0]         tag_id [MUL_LAT];
    logic               cap;
    logic [1:0]         cap_id;

    logic [63:0] prod [4];

    logic signed [64:0] d_sum, q_sum, d_shr, q_shr;
    logic [31:0]        d_sat, q_sat;

    // The multiplier cannot represent -2^31, so fold it onto -(2^31-1).
    function automatic logic [31:0] clamp(input logic [31:0] x);
        return (x == 32'h8000_0000) ? 32'h8000_0001 : x;
    endfunction

    function automatic logic [31:0] sat(input logic signed [64:0] x);
        if (x > POS_MAX)
            return 32'h7FFF_FFFF;
        else if (x < NEG_MAX)
            return 32'h8000_0001;
        else
            return x[31:0];
    endfunction

    assign cap    = tag_vld[MUL_LAT-1];
    assign cap_id = tag_id[MUL_LAT-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic and multiplier operand steering.
    always_comb begin
        state_nx = state;
        mul_a    = 32'd0;
        mul_b    = 32'd0;
        unique case (state)
            IDLE:  if (start) state_nx = ISSUE;
            ISSUE: begin
                if (cnt == 3'd3) state_nx = DRAIN;
                unique case (cnt[1:0])
                    2'd0: begin mul_a = alpha_q; mul_b = cos_q; end
                    2'd1: begin mul_a = beta_q;  mul_b = sin_q; end
                    2'd2: begin mul_a = beta_q;  mul_b = cos_q; end
                    2'd3: begin mul_a = alpha_q; mul_b = sin_q; end
                endcase
            end
            DRAIN: if (cap && cap_id == 2'd3) state_nx = SUM;
            SUM:   state_nx = OUT;
            OUT:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == OUT);

    // Operand latch on accepted start, with -2^31 clamping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alpha_q <= 32'd0;
            beta_q  <= 32'd0;
            sin_q   <= 32'd0;
            cos_q   <= 32'd0;
        end else if (state == IDLE && start) begin
            alpha_q <= clamp(i_alpha);
            beta_q  <= clamp(i_beta);
            sin_q   <= clamp(sin_th);
            cos_q   <= clamp(cos_th);
        end
    end

    // Issue counter: index of the product presented this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 3'd0;
        else if (state == ISSUE)
            cnt <= cnt + 3'd1;
        else
            cnt <= 3'd0;
    end

    // Tag pipeline tracks which product emerges from the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int i = 0; i < MUL_LAT; i++)
                tag_id[i] <= 2'd0;
        end else begin
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
            tag_vld[0] <= (state == ISSUE);
            tag_id[0]  <= cnt[1:0];
        end
    end

    // Product capture into the slot named by the emerging tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                prod[i] <= 64'd0;
        end else if (cap) begin
            prod[cap_id] <= mul_p;
        end
    end

    // Sum, round half-up, rescale and saturate.
    always_comb begin
        d_sum = $signed({prod[0][63], prod[0]})
              + $signed({prod[1][63], prod[1]});
        q_sum = $signed({prod[2][63], prod[2]})
              - $signed({prod[3][63], prod[3]});
        d_shr = (d_sum + RND) >>> FRAC_BITS;
        q_shr = (q_sum + RND) >>> FRAC_BITS;
        d_sat = sat(d_shr);
        q_sat = sat(q_shr);
    end

    // Result registers, loaded as the FSM enters OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_out <= 32'd0;
            iq_out <= 32'd0;
        end else if (state == SUM) begin
            id_out <= d_sat;
            iq_out <= q_sat;
        end
    end

endmodule

// File: tb/tb_park_mul_seq.sv
// Bench for park_mul_seq: pipelined multiplier model on mul_p and a
// plain-arithmetic Park reference with rounding and saturation.
module tb_park_mul_seq;

    localparam int FB  = 15;
    localparam int LAT = 2;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [31:0] i_alpha = 0, i_beta = 0, sin_th = 0, cos_th = 0;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_p;
    logic        busy, done;
    logic [31:0] id_out, iq_out;

    int n_tests = 0;
    int n_fail  = 0;

    park_mul_seq #(.FRAC_BITS(FB), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .i_alpha(i_alpha), .i_beta(i_beta),
        .sin_th(sin_th), .cos_th(cos_th),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .busy(busy), .done(done),
        .id_out(id_out), .iq_out(iq_out)
    );

    always #5 clk = ~clk;

    // Two-stage pipelined signed multiplier.
    logic signed [63:0] p0, p1;
    always @(posedge clk) begin
        p0 <= $signed(mul_a) * $signed(mul_b);
        p1 <= p0;
    end
    assign mul_p = p1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tb_clamp(input logic [31:0] x);
        return (x == 32'h8000_0000) ? 32'h8000_0001 : x;
    endfunction

    function automatic logic [31:0] fix(input logic signed [95:0] x);
        logic signed [95:0] r;
        r = x + 96'sd16384;
        r = r / 96'sd32768;
        if (r * 96'sd32768 > x + 96'sd16384) r = r - 96'sd1;
        if (r > 96'sd2147483647) return 32'h7FFF_FFFF;
        if (r < -96'sd2147483647) return 32'h8000_0001;
        return r[31:0];
    endfunction

    task automatic ref_park(input logic [31:0] a, b, s, c,
                            output logic [31:0] id, iq);
        logic signed [95:0] sa, sb, ss, sc;
        sa = $signed(tb_clamp(a));
        sb = $signed(tb_clamp(b));
        ss = $signed(tb_clamp(s));
        sc = $signed(tb_clamp(c));
        id = fix(sa * sc + sb * ss);
        iq = fix(sb * sc - sa * ss);
    endtask

    task automatic op(input logic [31:0] a, b, s, c, input string tag);
        logic [31:0] eid, eiq;
        int seen;
        ref_park(a, b, s, c, eid, eiq);
        @(posedge clk); #1;
        i_alpha = a; i_beta = b; sin_th = s; cos_th = c;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk({tag, "/busy"}, 64'(busy), 64'd1);
        chk({tag, "/mula"}, 64'(mul_a), 64'(tb_clamp(a)));
        chk({tag, "/mulb"}, 64'(mul_b), 64'(tb_clamp(c)));
        seen = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (done) begin
                seen = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "/lat"}, 64'(seen), 64'(6 + LAT));
        chk({tag, "/id"}, 64'(id_out), 64'(eid));
        chk({tag, "/iq"}, 64'(iq_out), 64'(eiq));
        @(posedge clk); #1;
        chk({tag, "/idle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int dones;
        logic [31:0] ra, rb, rs, rc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst/id", 64'(id_out), 64'd0);
        chk("rst/iq", 64'(iq_out), 64'd0);
        chk("rst/bd", 64'({busy, done}), 64'd0);
        chk("rst/mul", 64'({mul_a, mul_b}), 64'd0);
        rst_n = 1;

        op(32'd1000, -32'sd500, 32'd0, 32'd32768, "t1");
        op(32'd1000, -32'sd500, 32'd32768, 32'd0, "t2");
        op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd32768, 32'd32768, "t3");
        op(32'd1, 32'd0, 32'd0, 32'd16384, "t4a");
        op(-32'sd1, 32'd0, 32'd0, 32'd16384, "t4b");
        op(32'd3, 32'd0, 32'd0, 32'd16384, "t4c");
        op(32'h8000_0000, 32'd0, 32'd0, 32'd32768, "t5");
        chk("t5/abs", 64'(id_out), 64'h8000_0001);

        // Second start while busy must be dropped.
        @(posedge clk); #1;
        i_alpha = 32'd1000; i_beta = 32'd7; sin_th = 0; cos_th = 32'd32768;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        dones = 0;
        for (int cyc = 4; cyc <= 24; cyc++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        chk("t6/ndone", 64'(dones), 64'd1);
        chk("t6/id", 64'(id_out), 64'd1000);

        // Asynchronous reset mid-transform.
        @(posedge clk); #1;
        i_alpha = 32'd5000; i_beta = 32'd9; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("t6r/id", 64'(id_out), 64'd0);
        chk("t6r/iq", 64'(iq_out), 64'd0);
        chk("t6r/bd", 64'({busy, done}), 64'd0);
        chk("t6r/mul", 64'({mul_a, mul_b}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;
        dones = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        chk("t6r/ndone", 64'(dones), 64'd0);
        op(32'd1234, -32'sd4321, 32'd23170, 32'd23170, "t6n");

        // Randomised transforms.
        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 3 == 0) begin
                rs = $urandom;
                rc = $urandom;
            end else begin
                rs = 32'($urandom_range(65536)) - 32'd32768;
                rc = 32'($urandom_range(65536)) - 32'd32768;
            end
            if (k % 7 == 3) ra = 32'h8000_0000;
            if (k % 5 == 2) rs = 32'h8000_0000;
            op(ra, rb, rs, rc, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
